// File: rtl/multi_bus_arbiter_if.sv
// Bus bundle between the requester channels / main memory and the
// multi_bus_arbiter. The slave modport is the arbiter's view; the master
// modport is the environment's view (requesters plus the memory device).
interface multi_bus_arbiter_if #(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // requester side
  logic [N_CH-1:0]        start;
  logic [N_CH-1:0]        write_op;
  logic [N_CH*ADDR_W-1:0] in_address;
  logic [N_CH*DATA_W-1:0] in_data;
  logic [DATA_W-1:0]      out_data;
  logic [N_CH-1:0]        finish_flag;
  logic                   busy;
  logic                   timeout_flag;
  // memory side
  logic [ADDR_W-1:0]      mem_address;
  logic [DATA_W-1:0]      mem_data;
  logic                   mem_read_enable;
  logic                   mem_write_enable;
  logic [DATA_W-1:0]      mem_data_out;
  logic                   mem_readfinish_flag;
  logic                   mem_writefinish_flag;

  modport slave (
    input  start, write_op, in_address, in_data,
    input  mem_data_out, mem_readfinish_flag, mem_writefinish_flag,
    output out_data, finish_flag, busy, timeout_flag,
    output mem_address, mem_data, mem_read_enable, mem_write_enable
  );

  modport master (
    output start, write_op, in_address, in_data,
    output mem_data_out, mem_readfinish_flag, mem_writefinish_flag,
    input  out_data, finish_flag, busy, timeout_flag,
    input  mem_address, mem_data, mem_read_enable, mem_write_enable
  );
endinterface

// File: rtl/multi_bus_arbiter.sv
// multi_bus_arbiter: round-robin front end for N_CH requesters sharing one
// main-memory port. One transaction in flight at a time: IDLE grants,
// WAIT holds the memory strobe until the matching finish flag, DONE is a
// dead cycle that keeps a lingering memory finish level from being
// attributed to the next transaction.
// Optional feature: define BUS_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles (finish_flag and timeout_flag pulse together).
module multi_bus_arbiter #(
  parameter int N_CH           = 4,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               clk,
  input logic               rst,
  multi_bus_arbiter_if.slave bus
);

  localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;

  if (N_CH < 2 || N_CH > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("multi_bus_arbiter: N_CH must be 2..16 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [N_CH-1:0]   finish_q, finish_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;

`ifdef BUS_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  logic [ADDR_W-1:0] ch_addr [N_CH];
  logic [DATA_W-1:0] ch_data [N_CH];
  logic              req_any;
  logic [GW-1:0]     req_sel;
  logic              mem_done;

  // Unpack the flat per-channel address/data buses into arrays.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      ch_addr[c] = bus.in_address[c*ADDR_W +: ADDR_W];
      ch_data[c] = bus.in_data[c*DATA_W +: DATA_W];
    end
  end

  // Round-robin pick: first requesting channel at or after rr_ptr, wrapping.
  // Scanning from the far end lets the channel nearest rr_ptr win last.
  always_comb begin
    int            idx;
    logic [GW-1:0] idx_g;
    req_any = 1'b0;
    req_sel = '0;
    idx     = 0;
    idx_g   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_g = GW'(idx);
      if (bus.start[idx_g]) begin
        req_any = 1'b1;
        req_sel = idx_g;
      end
    end
  end

  // Only the finish flag matching the latched op counts; the other is ignored.
  assign mem_done = op_q ? bus.mem_writefinish_flag : bus.mem_readfinish_flag;

  // Next-state and registered-output logic for the IDLE/WAIT/DONE controller.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    out_data_d = out_data_q;
    finish_d   = '0;
    rd_en_d    = rd_en_q;
    wr_en_d    = wr_en_q;
`ifdef BUS_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d  = WAIT;
          grant_d  = req_sel;
          op_d     = bus.write_op[req_sel];
          addr_d   = ch_addr[req_sel];
          wdata_d  = ch_data[req_sel];
          rd_en_d  = ~bus.write_op[req_sel];
          wr_en_d  = bus.write_op[req_sel];
          rr_ptr_d = (req_sel == GW'(N_CH - 1)) ? '0 : req_sel + 1'b1;
`ifdef BUS_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      WAIT: begin
        if (mem_done) begin
          state_d           = DONE;
          rd_en_d           = 1'b0;
          wr_en_d           = 1'b0;
          finish_d[grant_q] = 1'b1;
          if (!op_q) out_data_d = bus.mem_data_out;
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d           = DONE;
          rd_en_d           = 1'b0;
          wr_en_d           = 1'b0;
          finish_d[grant_q] = 1'b1;
          timeout_d         = 1'b1;
          tmo_cnt_d         = tmo_cnt_q + 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      op_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      out_data_q <= '0;
      finish_q   <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      out_data_q <= out_data_d;
      finish_q   <= finish_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign bus.out_data         = out_data_q;
  assign bus.finish_flag      = finish_q;
  assign bus.busy             = busy_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_data         = wdata_q;
  assign bus.mem_read_enable  = rd_en_q;
  assign bus.mem_write_enable = wr_en_q;
`ifdef BUS_TIMEOUT_EN
  assign bus.timeout_flag     = timeout_q;
`else
  assign bus.timeout_flag     = 1'b0;
`endif

endmodule

// File: doc/multi_bus_arbiter.md
# multi_bus_arbiter

Parametrised N-channel front end to the shared main memory. Accepts independent read/write requests from up to N_CH requesters (cache controllers, DMA), grants one at a time by round-robin, drives the single memory port, and returns read data plus a per-channel one-cycle completion pulse. It replaces the single-requester bus block between the cache layer and Main_memory256 and adds arbitration, channel count, width generality and an optional timeout watchdog.

## Interface

Parameters:
- N_CH, 4, number of requester channels (2..16)
- ADDR_W, 8, address width
- DATA_W, 8, data width
- TIMEOUT_CYCLES, 64, max WAIT cycles before abort (used only with BUS_TIMEOUT_EN)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  N_CH  per-channel request, level; held until that channel's finish_flag
- write_op  in  N_CH  per-channel op: 1 write, 0 read
- in_address  in  N_CH*ADDR_W  channel c at [c*ADDR_W +: ADDR_W]
- in_data  in  N_CH*DATA_W  write data, channel c at [c*DATA_W +: DATA_W]
- out_data  out  DATA_W  read data of last completed read
- finish_flag  out  N_CH  one-hot, one-cycle completion pulse
- busy  out  1  high while not IDLE
- timeout_flag  out  1  one-cycle pulse with finish_flag on abort
- mem_address  out  ADDR_W  to memory
- mem_data  out  DATA_W  write data to memory
- mem_read_enable  out  1  memory read strobe, level
- mem_write_enable  out  1  memory write strobe, level
- mem_data_out  in  DATA_W  memory read data
- mem_readfinish_flag  in  1  memory read done
- mem_writefinish_flag  in  1  memory write done

## Operation

- States: IDLE, WAIT, DONE. Reset -> IDLE.
- IDLE: if any start bit high, grant the first requesting channel at or after rr_ptr (wrapping mod N_CH); latch address, data, op, grant index; drive the matching mem enable; go WAIT. rr_ptr <= grant+1 mod N_CH. No request: stay IDLE.
- WAIT: hold enable and mem_address/mem_data stable. Sample only the finish flag matching the latched op (other one ignored). On it: drop enable, pulse finish_flag[grant], for reads latch mem_data_out into out_data; go DONE.
- DONE: one dead cycle, no request accepted, so a lingering memory finish level is never attributed to a new transaction; -> IDLE.
- mem_read_enable and mem_write_enable never high together.
- start deasserted during WAIT: transaction still completes and pulses finish.
- Changes on in_address/in_data/write_op after grant are ignored.
- out_data holds until the next successful read; writes and aborts leave it unchanged.
- Reset at any point: IDLE, enables low, finish_flag 0, timeout_flag 0, busy 0, out_data 0, mem_address 0, mem_data 0, rr_ptr 0 (channel 0 highest priority); in-flight transaction is dropped with no finish pulse.

## Timing

- Request sampled at edge T -> mem enable, mem_address, busy high from T+1.
- Memory finish sampled high at edge F -> finish_flag[g] and out_data valid during F+1 (DONE); IDLE at F+2; next grant at edge F+2 at earliest.
- Minimum transaction spacing 3 cycles plus memory latency.
- Requester must drop start in the cycle finish_flag is high, otherwise re-granted as a new request.
- All outputs registered.

## Configuration

- BUS_TIMEOUT_EN defined: counter clears on entering WAIT and increments each WAIT cycle; if it reaches TIMEOUT_CYCLES with no matching memory finish, drop enable, pulse finish_flag[g] and timeout_flag together, out_data unchanged, go DONE. Counter width $clog2(TIMEOUT_CYCLES+1).
- Not defined: no counter; WAIT lasts until memory finishes (indefinitely); timeout_flag tied 0.

## Test plan

- Single read, N_CH=4: ch2 start, addr 0x3C, memory returns 0xA5 after 4 cycles -> mem_read_enable high for 5 cycles, finish_flag=4'b0100 one cycle, out_data=0xA5.
- Single write: ch0 writes 0x5A to 0x10 -> mem_write_enable high, mem_address=0x10, mem_data=0x5A, finish_flag=4'b0001; out_data unchanged.
- Round-robin: all four channels hold start from reset -> grants 0,1,2,3,0 in order, each finish pulse one-hot, never overlapping.
- Simultaneous finish flags: memory asserts both readfinish and writefinish during a write -> treated as write done, out_data unchanged.
- Reset mid-WAIT: rst asserted 2 cycles after grant -> next cycle enables low, busy 0, no finish pulse, rr_ptr back to 0.
- With BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never responds -> after 8 WAIT cycles finish_flag[g] and timeout_flag pulse together, enable drops; without macro, busy stays high.
